// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling tick positions.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_START  = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
  localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
  localparam logic [STATE_W-1:0] ST_STOP   = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } uart_state_t;

  // Tick index of the middle and of the end of a 16x-oversampled bit
  localparam int unsigned MID_TICK = 7;
  localparam int unsigned END_TICK = 15;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line plus falling-edge detector.
// All flops reset to 1 so an idle-high line never looks like a start edge.
module uart_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic rx,
  output logic rxs,
  output logic fall_c
);

  logic meta;
  logic hist;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      rxs  <= 1'b1;
      hist <= 1'b1;
    end else begin
      meta <= rx;
      rxs  <= meta;
      hist <= rxs;
    end
  end

  assign fall_c = hist & ~rxs;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, registered byte strobe with error flags.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16,
  parameter int unsigned PAR_ODD = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err
);

  // The stop period can reach 32 ticks, so the tick counter widens beyond 4 bits then
  localparam int unsigned S_W = (SB_TICK > 16) ? 5 : 4;
  localparam int unsigned N_W = 4;

  if (DBIT < 5 || DBIT > 9) begin : g_bad_dbit
    $error("uart_rx: DBIT must be 5..9");
  end
  if (SB_TICK < 16 || SB_TICK > 32) begin : g_bad_sb_tick
    $error("uart_rx: SB_TICK must be 16..32");
  end
  if (PAR_ODD > 1) begin : g_bad_par_odd
    $error("uart_rx: PAR_ODD must be 0 or 1");
  end

  uart_state_t     state, state_nx;
  logic [S_W-1:0]  s, s_nx;
  logic [N_W-1:0]  n, n_nx;
  logic [DBIT-1:0] b, b_nx;
  logic [DBIT-1:0] dout_nx;
  logic            done_nx;
  logic            ferr_nx;
  logic            rxs;
  logic            fall_c;

`ifdef UART_RX_PARITY_EN
  logic par_bit, par_bit_nx;
  logic perr_nx;
`endif

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx),
    .rxs     (rxs),
    .fall_c  (fall_c)
  );

  // State, counters, shift register and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      state        <= state_nx;
      s            <= s_nx;
      n            <= n_nx;
      b            <= b_nx;
      dout         <= dout_nx;
      rx_done_tick <= done_nx;
      frame_err    <= ferr_nx;
`ifdef UART_RX_PARITY_EN
      par_bit      <= par_bit_nx;
      parity_err   <= perr_nx;
`endif
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  // Next-state and next-output logic; counters only move on s_tick
  always_comb begin
    state_nx = state;
    s_nx     = s;
    n_nx     = n;
    b_nx     = b;
    dout_nx  = dout;
    done_nx  = 1'b0;
    ferr_nx  = frame_err;
`ifdef UART_RX_PARITY_EN
    par_bit_nx = par_bit;
    perr_nx    = parity_err;
`endif

    case (state)
      IDLE: begin
        if (fall_c) begin
          state_nx = START;
          s_nx     = '0;
        end
      end

      START: begin
        if (s_tick) begin
          if (s == S_W'(MID_TICK)) begin
            if (!rxs) begin
              s_nx     = '0;
              n_nx     = '0;
              state_nx = DATA;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            s_nx = s + S_W'(1);
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s == S_W'(END_TICK)) begin
            b_nx = {rxs, b[DBIT-1:1]};
            s_nx = '0;
            if (n == N_W'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_nx = PARITY;
`else
              state_nx = STOP;
`endif
            end else begin
              n_nx = n + N_W'(1);
            end
          end else begin
            s_nx = s + S_W'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s == S_W'(END_TICK)) begin
            par_bit_nx = rxs;
            s_nx       = '0;
            state_nx   = STOP;
          end else begin
            s_nx = s + S_W'(1);
          end
        end
      end
`endif

      STOP: begin
        if (s_tick) begin
          if (s == S_W'(SB_TICK - 1)) begin
            state_nx = IDLE;
            s_nx     = '0;
            done_nx  = 1'b1;
            dout_nx  = b;
            ferr_nx  = ~rxs;
`ifdef UART_RX_PARITY_EN
            perr_nx  = ((^b) ^ par_bit) != 1'(PAR_ODD);
`endif
          end else begin
            s_nx = s + S_W'(1);
          end
        end
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule
